// File: rtl/sequence_sort_n.sv
// Streaming frame sorter. Collects DEPTH unsigned samples per frame and keeps
// them ascending by inserting each new sample on arrival. The frame is then
// replayed in ascending or descending order, and its maximum and minimum are
// reported. Fill and drain never overlap.
module sequence_sort_n #(
  parameter int DW    = 3,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          desc,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic [DW-1:0] frame_max,
  output logic [DW-1:0] frame_min,
  output logic          mm_valid
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {FILL, DRAIN} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [CW-1:0] rd_idx;
  logic [CW-1:0] nxt_idx;
  logic [CW-1:0] pos;
  logic [DW-1:0] buf_q   [DEPTH];
  logic [DW-1:0] ins_buf [DEPTH];
  logic          desc_q;
  logic          accept;
  logic          xfer;
  logic          last_in;

  // Map a replay position to a buffer slot; descending reads from the top.
  function automatic logic [AW-1:0] sel(input logic [CW-1:0] idx, input logic d);
    logic [CW-1:0] s;
    s = d ? (CW'(DEPTH - 1) - idx) : idx;
    return s[AW-1:0];
  endfunction

  assign in_ready = (state == FILL);
  assign accept   = in_valid & in_ready;
  assign xfer     = out_valid & out_ready;
  assign last_in  = accept && (count == CW'(DEPTH - 1));
  assign nxt_idx  = rd_idx + 1'b1;

  // Insertion point: number of stored entries <= the new sample, so equal
  // values keep arrival order.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    pos = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count) && (buf_q[i] <= in_data)) pos = pos + 1'b1;
    end
  end

  // Buffer contents after inserting in_data at pos and shifting the tail up.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ins_buf[i] = buf_q[i];
      if (CW'(i) == pos) ins_buf[i] = in_data;
    end
    for (int i = 1; i < DEPTH; i++) begin
      if ((CW'(i) > pos) && (CW'(i) <= count)) ins_buf[i] = buf_q[i-1];
    end
  end

  // Fill/drain state machine with registered outputs; flush overrides all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      count     <= '0;
      rd_idx    <= '0;
      desc_q    <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      frame_max <= '0;
      frame_min <= '0;
      mm_valid  <= 1'b0;
      // NOTE: the sample buffer is reset too, so a read after reset is defined.
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update in this edge
      // based on pre-edge values, independent of statement order.
      mm_valid <= 1'b0;
      if (flush) begin
        state     <= FILL;
        count     <= '0;
        rd_idx    <= '0;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        case (state)
          FILL: begin
            if (accept) begin
              for (int i = 0; i < DEPTH; i++) buf_q[i] <= ins_buf[i];
              if (count == '0) desc_q <= desc;
              if (last_in) begin
                state     <= DRAIN;
                count     <= '0;
                rd_idx    <= '0;
                frame_min <= ins_buf[0];
                frame_max <= ins_buf[DEPTH-1];
                mm_valid  <= 1'b1;
                out_valid <= 1'b1;
                out_last  <= 1'b0;
                out_data  <= ins_buf[sel('0, desc_q)];
              end else begin
                count <= count + 1'b1;
              end
            end
          end
          DRAIN: begin
            if (xfer) begin
              if (out_last) begin
                state     <= FILL;
                rd_idx    <= '0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
              end else begin
                rd_idx   <= nxt_idx;
                out_data <= buf_q[sel(nxt_idx, desc_q)];
                out_last <= (nxt_idx == CW'(DEPTH - 1));
              end
            end
          end
          default: state <= FILL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sequence_sort_n.sv
// Directed bench for sequence_sort_n (DW=3, DEPTH=4): sorting in both
// orders, stalls, flush, asynchronous reset mid-drain and a counter source.
module tb_sequence_sort_n;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_data;
  logic       desc;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_data;
  logic       out_last;
  logic [2:0] frame_max;
  logic [2:0] frame_min;
  logic       mm_valid;

  int n_cmp = 0;
  int n_bad = 0;

  sequence_sort_n #(.DW(3), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .desc      (desc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .frame_max (frame_max),
    .frame_min (frame_min),
    .mm_valid  (mm_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample for one cycle; it must be accepted.
  task automatic push(input logic [2:0] d, input logic dsc);
    in_valid = 1'b1;
    in_data  = d;
    desc     = dsc;
    check("in_ready_fill", {7'd0, in_ready}, 8'd1);
    step();
    in_valid = 1'b0;
  endtask

  // Take one output with out_ready high and compare it.
  task automatic pull(input string tag, input logic [2:0] e, input logic last);
    out_ready = 1'b1;
    check({tag, "_valid"}, {7'd0, out_valid}, 8'd1);
    check({tag, "_data"},  {5'd0, out_data},  {5'd0, e});
    check({tag, "_last"},  {7'd0, out_last},  {7'd0, last});
    step();
  endtask

  task automatic check_mm(input string tag, input logic [2:0] mx, input logic [2:0] mn);
    check({tag, "_mm_valid"}, {7'd0, mm_valid}, 8'd1);
    check({tag, "_max"}, {5'd0, frame_max}, {5'd0, mx});
    check({tag, "_min"}, {5'd0, frame_min}, {5'd0, mn});
  endtask

  initial begin
    logic stall_pat [7];
    int   n_xfer;
    stall_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    desc      = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    #12;
    check("rst_in_ready",  {7'd0, in_ready},  8'd1);
    check("rst_out_valid", {7'd0, out_valid}, 8'd0);
    check("rst_out_last",  {7'd0, out_last},  8'd0);
    check("rst_mm_valid",  {7'd0, mm_valid},  8'd0);
    check("rst_out_data",  {5'd0, out_data},  8'd0);
    check("rst_max",       {5'd0, frame_max}, 8'd0);
    check("rst_min",       {5'd0, frame_min}, 8'd0);
    rst_n = 1'b1;
    step();

    // 1: ascending 5,2,7,2 -> 2,2,5,7
    push(3'd5, 1'b0); push(3'd2, 1'b0); push(3'd7, 1'b0); push(3'd2, 1'b0);
    check_mm("t1", 3'd7, 3'd2);
    check("t1_in_ready_drain", {7'd0, in_ready}, 8'd0);
    pull("t1_o0", 3'd2, 1'b0);
    check("t1_mm_pulse_end", {7'd0, mm_valid}, 8'd0);
    pull("t1_o1", 3'd2, 1'b0);
    pull("t1_o2", 3'd5, 1'b0);
    pull("t1_o3", 3'd7, 1'b1);
    check("t1_done_valid", {7'd0, out_valid}, 8'd0);
    check("t1_done_ready", {7'd0, in_ready},  8'd1);

    // 2: descending (latched with 1st sample) 1,6,3,0 -> 6,3,1,0
    push(3'd1, 1'b1); push(3'd6, 1'b0); push(3'd3, 1'b0); push(3'd0, 1'b0);
    check_mm("t2", 3'd6, 3'd0);
    pull("t2_o0", 3'd6, 1'b0);
    pull("t2_o1", 3'd3, 1'b0);
    pull("t2_o2", 3'd1, 1'b0);
    pull("t2_o3", 3'd0, 1'b1);

    // 3: 4,4,4,4 with stalls; in_valid held high in DRAIN must be ignored
    push(3'd4, 1'b0); push(3'd4, 1'b0); push(3'd4, 1'b0); push(3'd4, 1'b0);
    check_mm("t3", 3'd4, 3'd4);
    n_xfer   = 0;
    in_valid = 1'b1;
    in_data  = 3'd1;
    for (int c = 0; c < 7; c++) begin
      out_ready = stall_pat[c];
      check("t3_valid",    {7'd0, out_valid}, 8'd1);
      check("t3_in_ready", {7'd0, in_ready},  8'd0);
      check("t3_data",     {5'd0, out_data},  8'd4);
      check("t3_last",     {7'd0, out_last},  (n_xfer == 3) ? 8'd1 : 8'd0);
      if (stall_pat[c]) n_xfer++;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("t3_done_valid", {7'd0, out_valid}, 8'd0);

    // 4: flush after two accepts; sample offered in the flush cycle is dropped
    push(3'd6, 1'b0); push(3'd5, 1'b0);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 3'd7;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("t4_flush_valid", {7'd0, out_valid}, 8'd0);
    check("t4_flush_mm",    {7'd0, mm_valid},  8'd0);
    check("t4_flush_max",   {5'd0, frame_max}, 8'd4);
    push(3'd3, 1'b0); push(3'd1, 1'b0); push(3'd2, 1'b0); push(3'd0, 1'b0);
    check_mm("t4", 3'd3, 3'd0);
    pull("t4_o0", 3'd0, 1'b0);
    pull("t4_o1", 3'd1, 1'b0);
    pull("t4_o2", 3'd2, 1'b0);
    pull("t4_o3", 3'd3, 1'b1);

    // 5: async reset during the 2nd output of a drain
    push(3'd5, 1'b0); push(3'd0, 1'b0); push(3'd3, 1'b0); push(3'd6, 1'b0);
    check_mm("t5", 3'd6, 3'd0);
    pull("t5_o0", 3'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", {7'd0, out_valid}, 8'd0);
    check("t5_rst_max",   {5'd0, frame_max}, 8'd0);
    check("t5_rst_ready", {7'd0, in_ready},  8'd1);
    rst_n = 1'b1;
    step();
    push(3'd2, 1'b0); push(3'd7, 1'b0); push(3'd1, 1'b0); push(3'd1, 1'b0);
    check_mm("t5b", 3'd7, 3'd1);
    pull("t5b_o0", 3'd1, 1'b0);
    pull("t5b_o1", 3'd1, 1'b0);
    pull("t5b_o2", 3'd2, 1'b0);
    pull("t5b_o3", 3'd7, 1'b1);

    // 6: down-counter source; desc toggled mid-frame must be ignored
    push(3'd7, 1'b0); push(3'd6, 1'b1); push(3'd5, 1'b1); push(3'd4, 1'b0);
    check_mm("t6a", 3'd7, 3'd4);
    pull("t6a_o0", 3'd4, 1'b0);
    pull("t6a_o1", 3'd5, 1'b0);
    pull("t6a_o2", 3'd6, 1'b0);
    pull("t6a_o3", 3'd7, 1'b1);
    push(3'd3, 1'b0); push(3'd2, 1'b1); push(3'd1, 1'b0); push(3'd0, 1'b1);
    check_mm("t6b", 3'd3, 3'd0);
    pull("t6b_o0", 3'd0, 1'b0);
    pull("t6b_o1", 3'd1, 1'b0);
    pull("t6b_o2", 3'd2, 1'b0);
    pull("t6b_o3", 3'd3, 1'b1);
    push(3'd7, 1'b0); push(3'd6, 1'b0); push(3'd5, 1'b1); push(3'd4, 1'b1);
    check_mm("t6c", 3'd7, 3'd4);
    pull("t6c_o0", 3'd4, 1'b0);
    pull("t6c_o1", 3'd5, 1'b0);
    pull("t6c_o2", 3'd6, 1'b0);
    pull("t6c_o3", 3'd7, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
